// File: rtl/ibex_rf_wport_arbiter_if.sv
// Bundles the producer requests, the register-file write port and the CP
// scoreboard view that the write-port arbiter sits between.
interface ibex_rf_wport_arbiter_if;
  logic        lsu_we_i;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;

  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;

  logic        cp_issue_i;
  logic [4:0]  cp_issue_waddr_i;
  logic        cp_valid_i;
  logic        cp_ready_o;
  logic [4:0]  cp_waddr_i;
  logic [31:0] cp_wdata_i;

  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [2:0]  grant_o;
  logic [31:0] rf_pending_o;

  modport slave (
    input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    input  ex_valid_i, ex_waddr_i, ex_wdata_i,
    input  cp_issue_i, cp_issue_waddr_i, cp_valid_i, cp_waddr_i, cp_wdata_i,
    output ex_ready_o, cp_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o, grant_o, rf_pending_o
  );

  modport master (
    output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    output ex_valid_i, ex_waddr_i, ex_wdata_i,
    output cp_issue_i, cp_issue_waddr_i, cp_valid_i, cp_waddr_i, cp_wdata_i,
    input  ex_ready_o, cp_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, grant_o, rf_pending_o
  );
endinterface

// File: rtl/ibex_rf_wport_arbiter.sv
// Register-file write-port arbiter: LSU > starved CP > EX > CP, with a one-entry
// CP holding buffer and a pending-write scoreboard for CP destinations.
module ibex_rf_wport_arbiter #(
  parameter int unsigned StarveLimit = 4
) (
  input logic                    clk_i,
  input logic                    rst_i,
  ibex_rf_wport_arbiter_if.slave bus
);

  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  logic        cp_buf_valid_q, cp_buf_valid_d;
  logic [4:0]  cp_buf_addr_q, cp_buf_addr_d;
  logic [31:0] cp_buf_data_q, cp_buf_data_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:1] pend_q, pend_d;

  logic        force_cp;
  logic        cp_load;
  logic        cp_ready;
  logic [2:0]  grant;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pend_set, pend_clr, pend_full;

  assign force_cp  = cp_buf_valid_q & (starve_q == StarveMax);
  assign pend_full = {pend_q, 1'b0};

  // A starved CP result overtakes EX but never the LSU, which cannot stall.
  always_comb begin
    grant = 3'b000;
    if (bus.lsu_we_i)        grant = 3'b001;
    else if (force_cp)       grant = 3'b100;
    else if (bus.ex_valid_i) grant = 3'b010;
    else if (cp_buf_valid_q) grant = 3'b100;
  end

  always_comb begin
    waddr = 5'd0;
    wdata = 32'd0;
    unique case (grant)
      3'b001: begin waddr = bus.lsu_waddr_i; wdata = bus.lsu_wdata_i; end
      3'b010: begin waddr = bus.ex_waddr_i;  wdata = bus.ex_wdata_i;  end
      3'b100: begin waddr = cp_buf_addr_q;   wdata = cp_buf_data_q;   end
      default: ;
    endcase
  end

  // The buffer may drain and refill in one cycle, giving back-to-back CP writes.
  assign cp_ready = ~cp_buf_valid_q | grant[2];
  assign cp_load  = bus.cp_valid_i & cp_ready;

  always_comb begin
    cp_buf_valid_d = cp_load | (cp_buf_valid_q & ~grant[2]);
    cp_buf_addr_d  = cp_load ? bus.cp_waddr_i : cp_buf_addr_q;
    cp_buf_data_d  = cp_load ? bus.cp_wdata_i : cp_buf_data_q;

    starve_d = starve_q;
    if (~cp_buf_valid_q | grant[2]) starve_d = 4'd0;
    else if (starve_q < StarveMax)  starve_d = starve_q + 4'd1;

    // A same-register issue and retire leaves the bit set: the new issue wins.
    pend_set = bus.cp_issue_i ? (32'd1 << bus.cp_issue_waddr_i) : 32'd0;
    pend_clr = grant[2] ? (32'd1 << cp_buf_addr_q) : 32'd0;
    pend_d   = (pend_q & ~pend_clr[31:1]) | pend_set[31:1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cp_buf_valid_q <= 1'b0;
      cp_buf_addr_q  <= 5'd0;
      cp_buf_data_q  <= 32'd0;
      starve_q       <= 4'd0;
      pend_q         <= '0;
    end else begin
      cp_buf_valid_q <= cp_buf_valid_d;
      cp_buf_addr_q  <= cp_buf_addr_d;
      cp_buf_data_q  <= cp_buf_data_d;
      starve_q       <= starve_d;
      pend_q         <= pend_d;
    end
  end

  assign bus.grant_o      = grant;
  assign bus.rf_we_o      = |grant;
  assign bus.rf_waddr_o   = waddr;
  assign bus.rf_wdata_o   = wdata;
  assign bus.ex_ready_o   = grant[1];
  assign bus.cp_ready_o   = cp_ready;
  assign bus.rf_pending_o = pend_full;

  a_grant_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(grant));

  a_issue_not_pending : assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.cp_issue_i && (bus.cp_issue_waddr_i != 5'd0) && pend_full[bus.cp_issue_waddr_i])
    |-> (grant[2] && (cp_buf_addr_q == bus.cp_issue_waddr_i)));

  a_cp_result_pending : assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.cp_valid_i && cp_ready && (bus.cp_waddr_i != 5'd0)) |-> pend_full[bus.cp_waddr_i]);

  a_ex_hold : assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.ex_valid_i && !grant[1]) |=> bus.ex_valid_i);

endmodule
